// File: rtl/ek_if.sv
// ek byte stream channel: valid/ready handshake carrying one ek byte per
// transfer, with ek_last flagging the final byte of a frame.
//   master: drives ek_valid, ek_data, ek_last; samples ek_ready
//   slave : samples ek_valid, ek_data, ek_last; drives ek_ready
interface ek_if;
    logic       ek_valid;
    logic [7:0] ek_data;
    logic       ek_last;
    logic       ek_ready;

    modport master (
        output ek_valid,
        output ek_data,
        output ek_last,
        input  ek_ready
    );

    modport slave (
        input  ek_valid,
        input  ek_data,
        input  ek_last,
        output ek_ready
    );
endinterface

// File: rtl/ek_byte_encoder.sv
// Streams one 1184-byte ek frame: ByteEncode12 of three bank polynomials
// followed by the 32 rho bytes.
// Ports: clk/rst (sync, active-high); start/busy/done frame control;
//   poly_slot/poly_addr -> bank, poly_dout <- bank (1-cycle read latency);
//   rho_byte_idx -> rho store, rho_byte_in <- rho store (combinational);
//   ek (ek_if.master) byte stream out.
module ek_byte_encoder #(
    parameter logic [4:0] SLOT_T0 = 5'd0,
    parameter logic [4:0] SLOT_T1 = 5'd3,
    parameter logic [4:0] SLOT_T2 = 5'd6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  poly_slot,
    output logic [7:0]  poly_addr,
    input  logic [11:0] poly_dout,
    output logic [4:0]  rho_byte_idx,
    input  logic [7:0]  rho_byte_in,
    ek_if.master        ek
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        CAPT,
        EMIT,
        RHO_LOAD,
        RHO_EMIT
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  poly_q, poly_d;
    logic [6:0]  pair_q, pair_d;
    logic [4:0]  idx_q, idx_d;
    logic [1:0]  sel_q, sel_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [11:0] a_q, a_d;
    logic [23:0] sr_q, sr_d;
    logic [7:0]  rho_q, rho_d;
    logic        done_q, done_d;
    logic [4:0]  slot_sel;

    always_comb begin
        slot_sel = SLOT_T0;
        if (poly_q == 2'd1) slot_sel = SLOT_T1;
        if (poly_q == 2'd2) slot_sel = SLOT_T2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            poly_q     <= '0;
            pair_q     <= '0;
            idx_q      <= '0;
            sel_q      <= '0;
            byte_cnt_q <= '0;
            a_q        <= '0;
            sr_q       <= '0;
            rho_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            poly_q     <= poly_d;
            pair_q     <= pair_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            byte_cnt_q <= byte_cnt_d;
            a_q        <= a_d;
            sr_q       <= sr_d;
            rho_q      <= rho_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        poly_d       = poly_q;
        pair_d       = pair_q;
        idx_d        = idx_q;
        sel_d        = sel_q;
        byte_cnt_d   = byte_cnt_q;
        a_d          = a_q;
        sr_d         = sr_q;
        rho_d        = rho_q;
        done_d       = 1'b0;
        poly_slot    = '0;
        poly_addr    = '0;
        rho_byte_idx = '0;
        ek.ek_valid  = 1'b0;
        ek.ek_data   = '0;
        ek.ek_last   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH_A;
                    poly_d     = '0;
                    pair_d     = '0;
                    idx_d      = '0;
                    sel_d      = '0;
                    byte_cnt_d = '0;
                end
            end
            FETCH_A: begin
                poly_slot = slot_sel;
                poly_addr = {pair_q, 1'b0};
                state_d   = FETCH_B;
            end
            FETCH_B: begin
                // bank returns coef[2k] this cycle
                poly_slot = slot_sel;
                poly_addr = {pair_q, 1'b1};
                a_d       = poly_dout;
                state_d   = CAPT;
            end
            CAPT: begin
                // {b,a} little-endian is exactly the 3 output bytes
                sr_d    = {poly_dout, a_q};
                sel_d   = '0;
                state_d = EMIT;
            end
            EMIT: begin
                ek.ek_valid = 1'b1;
                ek.ek_data  = sr_q[7:0];
                if (ek.ek_ready) begin
                    byte_cnt_d = byte_cnt_q + 11'd1;
                    sr_d       = {8'h00, sr_q[23:8]};
                    if (sel_q == 2'd2) begin
                        sel_d = '0;
                        if (pair_q < 7'd127) begin
                            pair_d  = pair_q + 7'd1;
                            state_d = FETCH_A;
                        end else if (poly_q < 2'd2) begin
                            poly_d  = poly_q + 2'd1;
                            pair_d  = '0;
                            state_d = FETCH_A;
                        end else begin
                            idx_d   = '0;
                            state_d = RHO_LOAD;
                        end
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end
            end
            RHO_LOAD: begin
                rho_byte_idx = idx_q;
                rho_d        = rho_byte_in;
                state_d      = RHO_EMIT;
            end
            RHO_EMIT: begin
                ek.ek_valid = 1'b1;
                ek.ek_data  = rho_q;
                ek.ek_last  = (byte_cnt_q == 11'd1183);
                if (ek.ek_ready) begin
                    byte_cnt_d = byte_cnt_q + 11'd1;
                    if (idx_q < 5'd31) begin
                        idx_d   = idx_q + 5'd1;
                        state_d = RHO_LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_ek_byte_encoder.sv
// Bench for ek_byte_encoder: bank/rho models, a table of pair encodings,
// random coefficients and backpressure against a byte-stream reference.
module tb_ek_byte_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  poly_slot;
    logic [7:0]  poly_addr;
    logic [11:0] poly_dout;
    logic [4:0]  rho_byte_idx;
    logic [7:0]  rho_byte_in;

    always #5 clk = ~clk;

    ek_if ek();

    ek_byte_encoder #(
        .SLOT_T0(5'd0),
        .SLOT_T1(5'd3),
        .SLOT_T2(5'd6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .poly_slot(poly_slot),
        .poly_addr(poly_addr),
        .poly_dout(poly_dout),
        .rho_byte_idx(rho_byte_idx),
        .rho_byte_in(rho_byte_in),
        .ek(ek)
    );

    int SL[3] = '{0, 3, 6};

    logic [11:0] bank [0:31][0:255];
    logic [7:0]  rho_mem [0:31];

    always @(posedge clk) poly_dout <= bank[poly_slot][poly_addr];
    assign rho_byte_in = rho_mem[rho_byte_idx];

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_a[$];
    int last_pos[$];
    int cyc = 0;
    int first_cyc, start_cyc, last_cyc, done_cyc, done_cnt;
    bit done_busy;
    bit prev_stall = 0;
    bit prev_rst = 1;
    logic [7:0] prev_data;
    logic prev_last;

    always @(negedge clk) begin
        cyc++;
        if (prev_stall && !prev_rst) begin
            chk("stall_valid", int'(ek.ek_valid), 1);
            chk("stall_data", int'(ek.ek_data), int'(prev_data));
            chk("stall_last", int'(ek.ek_last), int'(prev_last));
        end
        prev_stall = ek.ek_valid && !ek.ek_ready;
        prev_data  = ek.ek_data;
        prev_last  = ek.ek_last;
        prev_rst   = rst;
        if (start && !busy && !rst && start_cyc < 0) start_cyc = cyc;
        if (ek.ek_valid && first_cyc < 0) first_cyc = cyc;
        if (ek.ek_valid && ek.ek_ready && !rst) begin
            got.push_back(ek.ek_data);
            if (ek.ek_last) begin
                last_pos.push_back(got.size() - 1);
                last_cyc = cyc;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
        end
    end

    function automatic void build_exp();
        logic [11:0] a, b;
        exp_q.delete();
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 128; k++) begin
                a = bank[SL[p]][2*k];
                b = bank[SL[p]][2*k+1];
                exp_q.push_back(a[7:0]);
                exp_q.push_back({b[3:0], a[11:8]});
                exp_q.push_back(b[11:4]);
            end
        for (int i = 0; i < 32; i++) exp_q.push_back(rho_mem[i]);
    endfunction

    task automatic reset_mon();
        got.delete();
        last_pos.delete();
        first_cyc = -1;
        start_cyc = -1;
        last_cyc  = -1;
        done_cyc  = -1;
        done_cnt  = 0;
    endtask

    task automatic run_frame(input int pct, input bit spam, input int stop_at);
        int n;
        reset_mon();
        @(posedge clk); #1;
        start    = 1'b1;
        ek.ek_ready = ($urandom_range(0, 99) < pct);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 20000 &&
               !(stop_at >= 0 && got.size() >= stop_at)) begin
            ek.ek_ready = ($urandom_range(0, 99) < pct);
            start = spam && busy && ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("frame_timeout", int'(n < 20000), 1);
    endtask

    task automatic check_frame();
        int bad;
        chk("byte_count", got.size(), 1184);
        bad = 0;
        for (int i = 0; i < 1184; i++)
            if (i >= got.size() || got[i] !== exp_q[i]) bad++;
        chk("stream_bytes_bad", bad, 0);
        chk("last_count", last_pos.size(), 1);
        chk("last_pos", last_pos.size() > 0 ? last_pos[0] : -1, 1183);
        chk("done_count", done_cnt, 1);
        chk("done_delay", done_cyc - last_cyc, 1);
        chk("done_busy", int'(done_busy), 0);
        chk("first_valid_lat", first_cyc - start_cyc, 4);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_valid"}, int'(ek.ek_valid), 0);
        chk({tag, "_last"}, int'(ek.ek_last), 0);
        chk({tag, "_data"}, int'(ek.ek_data), 0);
        chk({tag, "_slot"}, int'(poly_slot), 0);
        chk({tag, "_addr"}, int'(poly_addr), 0);
        chk({tag, "_ridx"}, int'(rho_byte_idx), 0);
    endtask

    typedef struct {
        int         poly;
        int         k;
        logic [11:0] a;
        logic [11:0] b;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [7:0]  e2;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int bad, nff, sz;
        tbl[0] = '{0, 0,   12'h123, 12'h456, 8'h23, 8'h61, 8'h45};
        tbl[1] = '{0, 5,   12'hFFF, 12'hFFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[2] = '{1, 0,   12'hABC, 12'hDEF, 8'hBC, 8'hFA, 8'hDE};
        tbl[3] = '{1, 64,  12'hD01, 12'hFFF, 8'h01, 8'hFD, 8'hFF};
        tbl[4] = '{2, 127, 12'h345, 12'h0A7, 8'h45, 8'h73, 8'h0A};
        tbl[5] = '{2, 10,  12'h800, 12'h001, 8'h00, 8'h18, 8'h00};
        tbl[6] = '{0, 127, 12'h000, 12'h000, 8'h00, 8'h00, 8'h00};

        for (int s = 0; s < 32; s++)
            for (int i = 0; i < 256; i++)
                bank[s][i] = 12'($urandom_range(0, 4095));
        for (int i = 0; i < 32; i++) rho_mem[i] = 8'(8'hA0 + i);
        for (int v = 0; v < 7; v++) begin
            bank[SL[tbl[v].poly]][2*tbl[v].k]   = tbl[v].a;
            bank[SL[tbl[v].poly]][2*tbl[v].k+1] = tbl[v].b;
        end

        rst = 1'b1;
        start = 1'b0;
        ek.ek_ready = 1'b0;
        reset_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame A: constant ready, table vectors embedded
        build_exp();
        run_frame(100, 0, -1);
        repeat (4) @(posedge clk);
        check_frame();
        for (int v = 0; v < 7; v++) begin
            int base;
            base = tbl[v].poly * 384 + 3 * tbl[v].k;
            sz = got.size();
            chk($sformatf("tbl%0d_b0", v),
                base < sz ? int'(got[base]) : -1, int'(tbl[v].e0));
            chk($sformatf("tbl%0d_b1", v),
                base + 1 < sz ? int'(got[base+1]) : -1, int'(tbl[v].e1));
            chk($sformatf("tbl%0d_b2", v),
                base + 2 < sz ? int'(got[base+2]) : -1, int'(tbl[v].e2));
        end
        sz = got.size();
        chk("slot3_coef0_at_384", sz > 384 ? int'(got[384]) : -1,
            int'(bank[3][0][7:0]));
        chk("rho_first", sz > 1152 ? int'(got[1152]) : -1, 'hA0);
        chk("rho_last", sz > 1183 ? int'(got[1183]) : -1, 'hBF);
        got_a = got;

        // Frame B: 30% ready with start spam while busy
        run_frame(30, 1, -1);
        repeat (4) @(posedge clk);
        check_frame();
        bad = 0;
        for (int i = 0; i < 1184; i++)
            if (i >= got.size() || i >= got_a.size() || got[i] !== got_a[i])
                bad++;
        chk("bp_vs_const_bad", bad, 0);

        // Frame C: all coefficients at 0xFFF
        for (int s = 0; s < 32; s++)
            for (int i = 0; i < 256; i++) bank[s][i] = 12'hFFF;
        build_exp();
        run_frame(100, 0, -1);
        repeat (4) @(posedge clk);
        check_frame();
        nff = 0;
        for (int i = 0; i < 1152 && i < got.size(); i++)
            if (got[i] == 8'hFF) nff++;
        chk("all_fff_bytes", nff, 1152);

        // Frame D: reset at byte 500, then a clean frame
        for (int s = 0; s < 32; s++)
            for (int i = 0; i < 256; i++)
                bank[s][i] = 12'($urandom_range(0, 4095));
        build_exp();
        run_frame(70, 0, 500);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        sz = got.size();
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("no_resume_busy", int'(busy), 0);
        chk("no_resume_bytes", got.size(), sz);
        run_frame(100, 0, -1);
        repeat (4) @(posedge clk);
        check_frame();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ek_byte_encoder.md
EK_BYTE_ENCODER -- requirements
Module: ek_byte_encoder

Interface
REQ-001 SHALL have parameter SLOT_T0, default 0: bank slot of t_hat[0].
REQ-002 SHALL have parameter SLOT_T1, default 3: bank slot of t_hat[1].
REQ-003 SHALL have parameter SLOT_T2, default 6: bank slot of t_hat[2].
REQ-004 SHALL have port clk  in  1: the single clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1: synchronous reset, active-high.
REQ-006 SHALL have port start  in  1: one-cycle request to emit one ek frame.
REQ-007 SHALL have port busy  out  1: frame in progress.
REQ-008 SHALL have port done  out  1: one-cycle pulse at frame completion.
REQ-009 SHALL have port poly_slot  out  5: bank read slot.
REQ-010 SHALL have port poly_addr  out  8: bank read coefficient index.
REQ-011 SHALL have port poly_dout  in  12: bank read data, valid exactly one cycle after slot/addr are presented.
REQ-012 SHALL have port rho_byte_idx  out  5: rho byte index 0..31.
REQ-013 SHALL have port rho_byte_in  in  8: rho byte, combinational from rho_byte_idx.
REQ-014 SHALL have port ek_valid  out  1: ek_data holds a valid byte.
REQ-015 SHALL have port ek_data  out  8: ek byte stream.
REQ-016 SHALL have port ek_last  out  1: marks byte 1183 of the frame.
REQ-017 SHALL have port ek_ready  in  1: sink accepts byte; transfer occurs when ek_valid and ek_ready are both 1.

Function
REQ-018 SHALL emit ek = ByteEncode12(t_hat[0]) || ByteEncode12(t_hat[1]) || ByteEncode12(t_hat[2]) || rho, 1184 bytes total, in this order.
REQ-019 SHALL encode coefficient pair a=coef[2k], b=coef[2k+1], k=0..127, as bytes a[7:0], {b[3:0],a[11:8]}, b[11:4], in this order.
REQ-020 SHALL pass 12-bit coefficients through unmodified, with no reduction or range check (values 3329..4095 are encoded as given).
REQ-021 SHALL use FSM states IDLE, FETCH_A, FETCH_B, CAPT, EMIT, RHO_LOAD, RHO_EMIT.
REQ-022 SHALL, in IDLE with start=1, go to FETCH_A next cycle with poly=0 and pair=0; busy goes 1 that same cycle.
REQ-023 SHALL, in FETCH_A, drive poly_addr=2k; in FETCH_B, drive poly_addr=2k+1 and register a; in CAPT, register b and load the 3-byte shift register; then go to EMIT.
REQ-024 SHALL drive poly_slot = SLOT_T0/SLOT_T1/SLOT_T2 for poly 0/1/2, and drive 0 when poly_addr is not in use.
REQ-025 SHALL assert ek_valid only in EMIT and RHO_EMIT; the first ek_valid occurs 4 cycles after the cycle in which start is sampled.
REQ-026 SHALL hold ek_data and ek_last stable while ek_valid=1 and ek_ready=0.
REQ-027 SHALL, on the third EMIT transfer: go to FETCH_A with pair+1 if pair<127; else go to FETCH_A with poly+1, pair=0 if poly<2; else go to RHO_LOAD with idx=0.
REQ-028 SHALL, in RHO_LOAD, drive rho_byte_idx=idx and register rho_byte_in into ek_data, then go to RHO_EMIT.
REQ-029 SHALL, on a RHO_EMIT transfer, go to RHO_LOAD with idx+1 if idx<31, else go to IDLE.
REQ-030 SHALL assert ek_last only while presenting rho byte 31.
REQ-031 SHALL pulse done for one cycle in the cycle after the ek_last transfer; busy is 0 in that cycle.
REQ-032 SHALL ignore start while busy=1.
REQ-033 SHALL keep internal 11-bit byte counter, 7-bit pair counter, 2-bit poly counter and 5-bit idx counter, and SHALL NOT wrap any of them within a frame.

Reset
REQ-034 SHALL, on rst=1 at any clock edge, including mid-frame, enter IDLE and drive busy=0, done=0, ek_valid=0, ek_last=0, ek_data=0, poly_slot=0, poly_addr=0, rho_byte_idx=0, and clear all counters.
REQ-035 SHALL resume only on a new start after reset is released; a partial frame is not resumed.

Verification
REQ-036 SHALL verify pair encoding: coef[0]=0x123, coef[1]=0x456 in slot 0 -> first bytes 0x23, 0x61, 0x45.
REQ-037 SHALL verify a full frame with ek_ready=1 constant and rho byte i=0xA0+i: exactly 1184 transfers, bytes 1152..1183 = 0xA0..0xBF, ek_last only on byte 1183, done 1 cycle later.
REQ-038 SHALL verify random backpressure (ek_ready 30% duty): byte stream identical to the constant-ready stream, and ek_data stable while stalled.
REQ-039 SHALL verify boundaries: all coefficients 0xFFF -> 1152 bytes of 0xFF; slot 3 coef[0] appears at byte 384.
REQ-040 SHALL verify that start pulses during busy cause no restart or duplicate bytes, and that rst asserted at byte 500 gives all outputs 0 the next cycle, followed by a clean full frame after a new start.
